din_debounce: RTL

DIN_DEBOUNCE -- requirements
Module: din_debounce

---
 rtl/din_debounce.sv | 64 ++++++
 1 files changed

// File: rtl/din_debounce.sv
// din_debounce: 8-bit input synchronizer/debouncer with edge pulses and sticky change flags.
module din_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iRaw,
    input  logic [7:0] iClr,
    output logic [7:0] oDeb,
    output logic [7:0] oRise,
    output logic [7:0] oFall,
    output logic [7:0] oEvt,
    output logic       oIrq
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [7:0]    s1, s2, upd;
    logic [CW-1:0] cnt [8];

    always_comb begin
        upd = '0;
        for (int i = 0; i < 8; i++)
            upd[i] = (s2[i] != oDeb[i]) && (cnt[i] == LAST);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= iRaw;
            s2 <= s1;
        end
    end

    // Any return to the debounced level, or a completed update, restarts the count.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < 8; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++)
                cnt[i] <= (s2[i] == oDeb[i] || upd[i]) ? '0 : cnt[i] + CW'(1);
        end
    end

    // Set wins over clear when an update and iClr land on the same edge.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDeb  <= '0;
            oRise <= '0;
            oFall <= '0;
            oEvt  <= '0;
        end else begin
            oDeb  <= oDeb ^ upd;
            oRise <= upd & s2;
            oFall <= upd & ~s2;
            oEvt  <= upd | (oEvt & ~iClr);
        end
    end

    assign oIrq = |oEvt;
endmodule
